// File: rtl/encdec_mul_pkg.sv
// Shared widths and the response record used by the multiplier arbiter and its pipeline.
package encdec_mul_pkg;

  localparam int A_W      = 14;
  localparam int B_W      = 16;
  localparam int P_W      = 30;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [P_W-1:0]      p;
  } resp_t;

endpackage

// File: rtl/encdec_mul_pipe.sv
// STAGES-deep unsigned multiplier; the requester id and a valid bit travel with the product.
module encdec_mul_pipe
  import encdec_mul_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic [A_W-1:0]            in_a,
  input  logic [B_W-1:0]            in_b,
  input  logic [ID_MAX_W-1:0]       in_id,
  output logic                      out_vld,
  output logic [$bits(resp_t)-1:0]  out_rsp,
  output logic [STAGES-1:0]         vld_vec
);

  logic [STAGES-1:0] vld_p;
  resp_t             res_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // stage 0 forms the full-width product; later stages only delay it
  always_ff @(posedge clk) begin
    res_p[0].id <= in_id;
    res_p[0].p  <= P_W'(in_a) * P_W'(in_b);
    for (int s = 1; s < STAGES; s++) res_p[s] <= res_p[s-1];
  end

  assign out_vld = vld_p[STAGES-1];
  assign out_rsp = res_p[STAGES-1];
  assign vld_vec = vld_p;

endmodule

// File: rtl/encdec_mul_arb.sv
// Round-robin arbiter feeding a shared multiplier with a credit-guarded response FIFO.
// Optional per-requester grant counters: define ENCDEC_MUL_ARB_STATS_EN.
module encdec_mul_arb
  import encdec_mul_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MUL_LAT   = 2,
  parameter int RSP_DEPTH = 4,
  localparam int ID_W     = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 arb_en,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*14-1:0]  req_a,
  input  logic [N_REQ*16-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [29:0]          rsp_p,
  output logic                 idle
`ifdef ENCDEC_MUL_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]  grant_cnt
`endif
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic                      rst_d, hold;
  logic [ID_W-1:0]           rr_ptr, win_id, scan_id;
  logic [ID_W:0]             scan;
  logic                      win_found, credit_ok, grant;
  int unsigned               occ;
  logic [A_W-1:0]            a_sel;
  logic [B_W-1:0]            b_sel;
  logic [MUL_LAT-1:0]        pipe_vld;
  logic                      pipe_out_vld;
  logic [$bits(resp_t)-1:0]  pipe_rsp;
  resp_t                     fifo_mem [RSP_DEPTH];
  resp_t                     head;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;
  logic                      push, pop;
  logic                      unused_id_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // first valid requester at or after rr_ptr, wrapping at N_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan      = '0;
    scan_id   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ)) scan = scan - (ID_W+1)'(N_REQ);
      scan_id = scan[ID_W-1:0];
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // credit counts both in-flight products and queued responses
  always_comb begin
    occ = 32'(fifo_cnt);
    for (int s = 0; s < MUL_LAT; s++) occ = occ + 32'(pipe_vld[s]);
  end

  assign credit_ok = occ < 32'(RSP_DEPTH);
  assign hold      = ap_rst | rst_d;
  assign grant     = arb_en & credit_ok & win_found & ~hold;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  encdec_mul_pipe #(
    .STAGES (MUL_LAT)
  ) u_pipe (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .in_vld  (grant),
    .in_a    (a_sel),
    .in_b    (b_sel),
    .in_id   (ID_MAX_W'(win_id)),
    .out_vld (pipe_out_vld),
    .out_rsp (pipe_rsp),
    .vld_vec (pipe_vld)
  );

  assign push = pipe_out_vld;
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge ap_clk) begin
    rst_d <= ap_rst;
    if (ap_rst) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (grant) rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      if (push)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr] <= pipe_rsp;
  end

  assign head           = fifo_mem[rd_ptr];
  assign unused_id_bits = ^head.id;
  assign rsp_valid      = (fifo_cnt != '0) & ~ap_rst;
  assign rsp_id         = rsp_valid ? head.id[ID_W-1:0] : '0;
  assign rsp_p          = rsp_valid ? head.p : '0;
  assign idle           = ap_rst | ((pipe_vld == '0) & (fifo_cnt == '0));

`ifdef ENCDEC_MUL_ARB_STATS_EN
  logic [15:0] gcnt [N_REQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < N_REQ; i++) gcnt[i] <= '0;
    end else if (grant) begin
      for (int i = 0; i < N_REQ; i++)
        if (ID_W'(i) == win_id) gcnt[i] <= sat_inc(gcnt[i]);
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*16 +: 16] = gcnt[i];
  end
`endif

endmodule
